// File: rtl/game_sequencer.sv
// game_sequencer: Init/Prepare/InGame/Dead flow with BCD score and high score tracking
module game_sequencer #(
   parameter int PREP_FRAMES      = 60,
   parameter int DEAD_LOCK_FRAMES = 30,
   parameter int SCORE_DIV        = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        btn_jump,
   input  logic        collision,
   output logic [1:0]  game_state,
   output logic        run_en,
   output logic        world_reset,
   output logic [15:0] score,
   output logic [15:0] high_score,
   output logic        new_high
);
   typedef enum logic [1:0] {INIT = 2'b00, IN_GAME = 2'b01, PREP = 2'b10, DEAD = 2'b11} state_t;
   state_t      state;
   logic [7:0]  cnt;
   logic [7:0]  div;
   logic        lock_done;
   logic        btn_prev;
   logic        press;
   logic        carry;
   logic [15:0] score_inc;
   assign press      = btn_jump & ~btn_prev;
   assign game_state = state;
   // BCD increment of the current score, holding at 9999
   always_comb begin
      carry     = 1'b1;
      score_inc = score;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            score_inc[4*i+:4] = (score[4*i+:4] == 4'd9) ? 4'd0 : score[4*i+:4] + 4'd1;
            carry             = (score[4*i+:4] == 4'd9);
         end
      end
      if (score == 16'h9999) score_inc = score;
   end
   // game flow state machine; collision has priority over a same-cycle score tick
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= INIT;
         run_en      <= 1'b0;
         world_reset <= 1'b0;
         score       <= '0;
         high_score  <= '0;
         new_high    <= 1'b0;
         cnt         <= '0;
         div         <= '0;
         lock_done   <= 1'b0;
         btn_prev    <= 1'b0;
      end else begin
         btn_prev    <= btn_jump;
         world_reset <= 1'b0;
         if (press && (state == INIT || (state == DEAD && lock_done))) begin
            state       <= PREP;
            world_reset <= 1'b1;
            score       <= '0;
            div         <= '0;
            new_high    <= 1'b0;
            cnt         <= 8'(PREP_FRAMES - 1);
         end else if (state == PREP && frame_tick) begin
            if (cnt == '0) begin
               state  <= IN_GAME;
               run_en <= 1'b1;
            end else begin
               cnt <= cnt - 8'd1;
            end
         end else if (state == IN_GAME && collision) begin
            state     <= DEAD;
            run_en    <= 1'b0;
            cnt       <= 8'(DEAD_LOCK_FRAMES - 1);
            lock_done <= 1'b0;
            if (score > high_score) begin
               high_score <= score;
               new_high   <= 1'b1;
            end
         end else if (state == IN_GAME && frame_tick) begin
            div <= (div == 8'(SCORE_DIV - 1)) ? 8'd0 : div + 8'd1;
            if (div == 8'(SCORE_DIV - 1)) score <= score_inc;
         end else if (state == DEAD && frame_tick) begin
            if (cnt == '0) lock_done <= 1'b1;
            else cnt <= cnt - 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: vector table, directed corner sequences and random run against a reference model
module tb_game_sequencer;
   logic        clk = 1'b0;
   logic        rst, frame_tick, btn_jump, collision;
   logic [1:0]  game_state;
   logic        run_en, world_reset, new_high;
   logic [15:0] score, high_score;
   int n_asrt = 0;
   int n_fail = 0;
   game_sequencer #(.PREP_FRAMES(3), .DEAD_LOCK_FRAMES(2), .SCORE_DIV(2)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_jump(btn_jump), .collision(collision),
      .game_state(game_state), .run_en(run_en), .world_reset(world_reset),
      .score(score), .high_score(high_score), .new_high(new_high)
   );
   always #5 clk = ~clk;
   // reference model: phase 0 Init, 1 InGame, 2 Prepare, 3 Dead; scores kept as plain integers
   int m_phase, m_ticks, m_score, m_high;
   bit m_new, m_wr, m_prev;
   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_asrt++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic model_step(input bit r, input bit t, input bit b, input bit c);
      bit p;
      if (r) begin
         m_phase = 0; m_ticks = 0; m_score = 0; m_high = 0; m_new = 0; m_wr = 0; m_prev = 0;
         return;
      end
      p      = b && !m_prev;
      m_prev = b;
      m_wr   = 0;
      if (p && (m_phase == 0 || (m_phase == 3 && m_ticks >= 2))) begin
         m_phase = 2; m_ticks = 0; m_score = 0; m_new = 0; m_wr = 1;
      end else if (m_phase == 2 && t) begin
         m_ticks++;
         if (m_ticks == 3) begin m_phase = 1; m_ticks = 0; end
      end else if (m_phase == 1 && c) begin
         m_phase = 3; m_ticks = 0;
         if (m_score > m_high) begin m_high = m_score; m_new = 1; end
      end else if (m_phase == 1 && t) begin
         m_ticks++;
         if (m_ticks % 2 == 0 && m_score < 9999) m_score++;
      end else if (m_phase == 3 && t) begin
         m_ticks++;
      end
   endtask
   task automatic cyc(input bit r, input bit t, input bit b, input bit c);
      rst = r; frame_tick = t; btn_jump = b; collision = c;
      model_step(r, t, b, c);
      @(posedge clk);
      #1;
      chk("state", 32'(game_state), 32'(m_phase));
      chk("run_en", 32'(run_en), 32'(m_phase == 1));
      chk("world_reset", 32'(world_reset), 32'(m_wr));
      chk("score", 32'(score), 32'(to_bcd(m_score)));
      chk("high_score", 32'(high_score), 32'(to_bcd(m_high)));
      chk("new_high", 32'(new_high), 32'(m_new));
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
   endtask
   task automatic press();
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
   endtask
   typedef struct {
      bit r, t, b, c;
      logic [1:0] st;
      logic run, wr;
      logic [15:0] sc, hi;
      logic nh;
   } vec_t;
   vec_t tbl[16];
   initial begin
      tbl[0]  = '{1, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};
      tbl[1]  = '{0, 0, 1, 0, 2'b10, 0, 1, 16'h0000, 16'h0000, 0};
      tbl[2]  = '{0, 0, 1, 0, 2'b10, 0, 0, 16'h0000, 16'h0000, 0};
      tbl[3]  = '{0, 1, 0, 0, 2'b10, 0, 0, 16'h0000, 16'h0000, 0};
      tbl[4]  = '{0, 1, 1, 1, 2'b10, 0, 0, 16'h0000, 16'h0000, 0};
      tbl[5]  = '{0, 0, 0, 0, 2'b10, 0, 0, 16'h0000, 16'h0000, 0};
      tbl[6]  = '{0, 1, 0, 0, 2'b01, 1, 0, 16'h0000, 16'h0000, 0};
      tbl[7]  = '{0, 1, 0, 0, 2'b01, 1, 0, 16'h0000, 16'h0000, 0};
      tbl[8]  = '{0, 1, 0, 0, 2'b01, 1, 0, 16'h0001, 16'h0000, 0};
      tbl[9]  = '{0, 1, 1, 0, 2'b01, 1, 0, 16'h0001, 16'h0000, 0};
      tbl[10] = '{0, 1, 0, 0, 2'b01, 1, 0, 16'h0002, 16'h0000, 0};
      tbl[11] = '{0, 0, 0, 1, 2'b11, 0, 0, 16'h0002, 16'h0002, 1};
      tbl[12] = '{0, 0, 1, 0, 2'b11, 0, 0, 16'h0002, 16'h0002, 1};
      tbl[13] = '{0, 1, 0, 0, 2'b11, 0, 0, 16'h0002, 16'h0002, 1};
      tbl[14] = '{0, 1, 0, 0, 2'b11, 0, 0, 16'h0002, 16'h0002, 1};
      tbl[15] = '{0, 0, 1, 0, 2'b10, 0, 1, 16'h0000, 16'h0002, 0};
      rst = 1; frame_tick = 0; btn_jump = 0; collision = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].r, tbl[i].t, tbl[i].b, tbl[i].c);
         chk($sformatf("vec%0d_state", i), 32'(game_state), 32'(tbl[i].st));
         chk($sformatf("vec%0d_run", i), 32'(run_en), 32'(tbl[i].run));
         chk($sformatf("vec%0d_wr", i), 32'(world_reset), 32'(tbl[i].wr));
         chk($sformatf("vec%0d_score", i), 32'(score), 32'(tbl[i].sc));
         chk($sformatf("vec%0d_high", i), 32'(high_score), 32'(tbl[i].hi));
         chk($sformatf("vec%0d_nh", i), 32'(new_high), 32'(tbl[i].nh));
      end
      // collision coinciding with a scoring tick at 0004, then a weaker second run
      cyc(1, 0, 0, 0);
      press();
      ticks(3);
      ticks(9);
      chk("pre_col_score", 32'(score), 32'h0004);
      cyc(0, 1, 0, 1);
      chk("col_state", 32'(game_state), 32'h3);
      chk("col_score", 32'(score), 32'h0004);
      chk("col_high", 32'(high_score), 32'h0004);
      chk("col_new_high", 32'(new_high), 32'h1);
      press();
      chk("lock_press_ignored", 32'(game_state), 32'h3);
      ticks(2);
      cyc(0, 0, 1, 0);
      chk("restart_state", 32'(game_state), 32'h2);
      chk("restart_wr", 32'(world_reset), 32'h1);
      chk("restart_score", 32'(score), 32'h0000);
      chk("restart_nh", 32'(new_high), 32'h0);
      cyc(0, 0, 0, 0);
      chk("restart_wr_one_cycle", 32'(world_reset), 32'h0);
      ticks(3);
      ticks(4);
      cyc(0, 0, 0, 1);
      chk("run2_score", 32'(score), 32'h0002);
      chk("run2_high", 32'(high_score), 32'h0004);
      chk("run2_nh", 32'(new_high), 32'h0);
      // reset in the middle of a game clears everything including the high score
      ticks(2);
      press();
      ticks(3);
      ticks(14);
      chk("mid_score", 32'(score), 32'h0007);
      cyc(1, 1, 1, 1);
      chk("rst_state", 32'(game_state), 32'h0);
      chk("rst_run", 32'(run_en), 32'h0);
      chk("rst_score", 32'(score), 32'h0000);
      chk("rst_high", 32'(high_score), 32'h0000);
      chk("rst_nh", 32'(new_high), 32'h0);
      // score saturation at 9999
      cyc(0, 0, 0, 0);
      press();
      ticks(3);
      ticks(19998);
      chk("sat_reach", 32'(score), 32'h9999);
      ticks(2);
      chk("sat_hold", 32'(score), 32'h9999);
      cyc(0, 0, 0, 1);
      chk("sat_high", 32'(high_score), 32'h9999);
      // random traffic against the model
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
